// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the A,B,E,7,F,2,0,D link pattern. The generator and
// the checker both pull the symbol table from here so the two ends of the
// link can never disagree about the pattern.
//
// Contents:
//   SEQ_LEN    - number of symbols in one period of the pattern
//   IDX_W      - width of a slot pointer into the pattern
//   sym_t      - one 4-bit link symbol
//   idx_t      - slot pointer, wraps naturally at SEQ_LEN
//   SEQ        - the pattern itself, slot 0 first
//   SYNC_SYM   - the symbol that starts every period (used for acquisition)
//   state_e    - checker alignment state
//   seqSymbol  - symbol expected in a given slot
//   nextIdx    - slot pointer advance with wrap
// ---------------------------------------------------------------------------
package seq_pkg;

    localparam int SEQ_LEN = 8;
    localparam int IDX_W   = 3;

    typedef logic [3:0]       sym_t;
    typedef logic [IDX_W-1:0] idx_t;

    localparam sym_t SEQ [SEQ_LEN] = '{4'hA, 4'hB, 4'hE, 4'h7,
                                        4'hF, 4'h2, 4'h0, 4'hD};

    localparam sym_t SYNC_SYM = 4'hA;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // Look up the symbol that belongs in a slot of the pattern.
    function automatic sym_t seqSymbol(input idx_t idx);
        return SEQ[idx];
    endfunction

    // Advance a slot pointer. SEQ_LEN is a power of two, so the natural
    // 3-bit overflow gives the 7 -> 0 wrap for free.
    function automatic idx_t nextIdx(input idx_t idx);
        return idx + idx_t'(1);
    endfunction

endpackage

// File: rtl/seq_err_counter.sv
// ---------------------------------------------------------------------------
// seq_err_counter
// Saturating up-counter with a synchronous clear. Used by the checker to
// accumulate locked-state symbol errors without ever wrapping back to a
// small (misleadingly healthy) value.
//
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   synchronous active-low reset, clears the count
//   clr_i    in   synchronous clear, wins over a simultaneous increment
//   inc_i    in   count one event this cycle
//   count_o  out  current count, holds at all-ones once saturated
// ---------------------------------------------------------------------------
module seq_err_counter
    import seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: a clear always wins so software can zero the counter even
    // while errors are streaming in; otherwise increment unless the counter
    // is already pinned at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/sequence_checker.sv
// ---------------------------------------------------------------------------
// sequence_checker
// Receive-side link-integrity monitor for the A,B,E,7,F,2,0,D pattern.
// It hunts for the sync symbol A, verifies a run of LOCK_LEN correct
// symbols before declaring lock, then flywheels through the pattern while
// flagging and counting mismatches. LOSS_THRESH consecutive misses drop it
// back to hunting.
//
// Parameters:
//   LOCK_LEN     correct symbols (starting at A) needed to lock, 2..16
//   LOSS_THRESH  consecutive locked misses that force loss of lock, 1..15
//   CNT_W        width of the saturating error counter
//
// Ports:
//   clk          in   clock, rising edge
//   reset_n      in   synchronous active-low reset
//   valid        in   symbol qualifier; nothing advances while low
//   data         in   received 4-bit symbol
//   clr_count    in   synchronous clear of err_count
//   locked       out  high while aligned and locked
//   error        out  one-cycle pulse for a locked-state mismatch
//   period_done  out  one-cycle pulse when the last slot (D) was sampled
//                     while locked, whether it matched or not
//   expected     out  symbol expected at the next valid sample
//   err_count    out  saturating count of locked-state mismatches
//
// Every output is a flop, so pulses appear in the cycle after the edge
// that sampled the symbol.
// ---------------------------------------------------------------------------
module sequence_checker
    import seq_pkg::*;
#(
    parameter int LOCK_LEN    = 8,
    parameter int LOSS_THRESH = 3,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    input  logic [3:0]       data,
    input  logic             clr_count,
    output logic             locked,
    output logic             error,
    output logic             period_done,
    output logic [3:0]       expected,
    output logic [CNT_W-1:0] err_count
);

    // The match counter must reach 16 and the miss counter 15, so they are
    // sized for the top of the legal parameter ranges.
    localparam int MATCH_W = 5;
    localparam int MISS_W  = 4;

    localparam logic [MATCH_W-1:0] LOCK_LEN_C    = MATCH_W'(LOCK_LEN);
    localparam logic [MISS_W-1:0]  LOSS_THRESH_C = MISS_W'(LOSS_THRESH);
    localparam idx_t               LAST_IDX      = idx_t'(SEQ_LEN - 1);

    state_e             state_q;
    state_e             state_d;
    idx_t               idx_q;
    idx_t               idx_d;
    logic [MATCH_W-1:0] matchCnt_q;
    logic [MATCH_W-1:0] matchCnt_d;
    logic [MISS_W-1:0]  missCnt_q;
    logic [MISS_W-1:0]  missCnt_d;

    logic               locked_q;
    logic               locked_d;
    logic               error_q;
    logic               error_d;
    logic               periodDone_q;
    logic               periodDone_d;
    sym_t               expected_q;
    sym_t               expected_d;

    logic               symHit;
    logic               symIsSync;
    logic [MATCH_W-1:0] matchNext;
    logic [MISS_W-1:0]  missNext;

    // Compare the incoming symbol against the slot we are pointing at, and
    // separately against the sync symbol so a stray A during verification
    // can restart alignment instead of dropping all the way back to hunt.
    always_comb begin
        symHit    = (data == seqSymbol(idx_q));
        symIsSync = (data == SYNC_SYM);
        matchNext = matchCnt_q + MATCH_W'(1);
        missNext  = missCnt_q + MISS_W'(1);
    end

    // State register. Reset is synchronous and overrides any sample taking
    // place in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= HUNT;
            idx_q        <= '0;
            matchCnt_q   <= '0;
            missCnt_q    <= '0;
            locked_q     <= 1'b0;
            error_q      <= 1'b0;
            periodDone_q <= 1'b0;
            expected_q   <= SYNC_SYM;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            matchCnt_q   <= matchCnt_d;
            missCnt_q    <= missCnt_d;
            locked_q     <= locked_d;
            error_q      <= error_d;
            periodDone_q <= periodDone_d;
            expected_q   <= expected_d;
        end
    end

    // Next-state logic. Everything holds while valid is low. In HUNT and
    // VERIFY the slot pointer follows the received data; once LOCKED it
    // free-runs (flywheel) and never realigns, so a burst of bad symbols can
    // only cost lock, never shift the phase.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        matchCnt_d = matchCnt_q;
        missCnt_d  = missCnt_q;

        if (valid) begin
            unique case (state_q)
                HUNT: begin
                    if (symIsSync) begin
                        state_d    = VERIFY;
                        idx_d      = idx_t'(1);
                        matchCnt_d = MATCH_W'(1);
                    end
                end

                VERIFY: begin
                    if (symHit) begin
                        idx_d      = nextIdx(idx_q);
                        matchCnt_d = matchNext;
                        if (matchNext == LOCK_LEN_C) begin
                            state_d   = LOCKED;
                            missCnt_d = '0;
                        end
                    end else if (symIsSync) begin
                        state_d    = VERIFY;
                        idx_d      = idx_t'(1);
                        matchCnt_d = MATCH_W'(1);
                    end else begin
                        state_d    = HUNT;
                        idx_d      = '0;
                        matchCnt_d = '0;
                    end
                end

                LOCKED: begin
                    idx_d = nextIdx(idx_q);
                    if (symHit) begin
                        missCnt_d = '0;
                    end else begin
                        missCnt_d = missNext;
                        if (missNext == LOSS_THRESH_C) begin
                            state_d    = HUNT;
                            idx_d      = '0;
                            missCnt_d  = '0;
                            matchCnt_d = '0;
                        end
                    end
                end

                default: begin
                    state_d    = HUNT;
                    idx_d      = '0;
                    matchCnt_d = '0;
                    missCnt_d  = '0;
                end
            endcase
        end
    end

    // Output logic. The values computed here are registered, so locked
    // follows the state we are entering and the pulses describe the symbol
    // sampled on this edge. expected tracks the slot pointer we are moving
    // to, so it always names the symbol wanted at the next valid sample.
    always_comb begin
        locked_d     = (state_d == LOCKED);
        error_d      = valid && (state_q == LOCKED) && !symHit;
        periodDone_d = valid && (state_q == LOCKED) && (idx_q == LAST_IDX);
        expected_d   = seqSymbol(idx_d);
    end

    // Locked-state mismatches feed the saturating error counter; the
    // increment lines up with the error pulse so both become visible in the
    // same cycle.
    seq_err_counter #(
        .CNT_W (CNT_W)
    ) u_errCounter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (clr_count),
        .inc_i   (error_d),
        .count_o (err_count)
    );

    assign locked      = locked_q;
    assign error       = error_q;
    assign period_done = periodDone_q;
    assign expected    = expected_q;

endmodule

// File: tb/tb_sequence_checker.sv
// ---------------------------------------------------------------------------
// tb_sequence_checker
// Drives two checkers with identical stimulus: one with default parameters
// and one with a 2-bit counter and a loss threshold of 15 (for saturation).
// A behavioural model of each checker predicts every output after every
// clock edge; a handful of directed expectations pin down key moments.
// ---------------------------------------------------------------------------
module tb_sequence_checker;

    localparam logic [3:0] SEQ_TB [8] = '{4'hA, 4'hB, 4'hE, 4'h7,
                                          4'hF, 4'h2, 4'h0, 4'hD};

    localparam int LOCK_M  [2] = '{8, 8};
    localparam int LOSS_M  [2] = '{3, 15};
    localparam int ERRMAX_M[2] = '{255, 3};

    logic       clk;
    logic       reset_n;
    logic       valid;
    logic [3:0] data;
    logic       clr_count;

    logic       lockedA, errorA, pdA;
    logic [3:0] expA;
    logic [7:0] cntA;
    logic       lockedB, errorB, pdB;
    logic [3:0] expB;
    logic [1:0] cntB;

    int testCount = 0;
    int failCount = 0;
    int cyc       = 0;
    int txPhase   = 0;

    bit mLock    [2];
    int mRun     [2];
    int mPhase   [2];
    int mMiss    [2];
    int mErr     [2];
    bit mErrPulse[2];
    bit mPd      [2];

    sequence_checker dutA (
        .clk         (clk),
        .reset_n     (reset_n),
        .valid       (valid),
        .data        (data),
        .clr_count   (clr_count),
        .locked      (lockedA),
        .error       (errorA),
        .period_done (pdA),
        .expected    (expA),
        .err_count   (cntA)
    );

    sequence_checker #(
        .LOCK_LEN    (8),
        .LOSS_THRESH (15),
        .CNT_W       (2)
    ) dutB (
        .clk         (clk),
        .reset_n     (reset_n),
        .valid       (valid),
        .data        (data),
        .clr_count   (clr_count),
        .locked      (lockedB),
        .error       (errorB),
        .period_done (pdB),
        .expected    (expB),
        .err_count   (cntB)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and on mismatch counts the failure and
    // reports the tag with observed and expected values.
    task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        testCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural prediction of both checkers for one clock edge. Alignment
    // is tracked as "how many correct symbols in a row since an A" plus the
    // pattern phase, rather than as explicit FSM states.
    task automatic modelStep(input bit v, input logic [3:0] d, input bit clr, input bit rstn);
        logic [3:0] want;
        for (int k = 0; k < 2; k++) begin
            mErrPulse[k] = 1'b0;
            mPd[k]       = 1'b0;
            if (!rstn) begin
                mLock[k]  = 1'b0;
                mRun[k]   = 0;
                mPhase[k] = 0;
                mMiss[k]  = 0;
                mErr[k]   = 0;
            end else begin
                if (v) begin
                    want = SEQ_TB[mPhase[k]];
                    if (mLock[k]) begin
                        mPd[k]    = (mPhase[k] == 7);
                        mPhase[k] = (mPhase[k] + 1) % 8;
                        if (d == want) begin
                            mMiss[k] = 0;
                        end else begin
                            mErrPulse[k] = 1'b1;
                            mMiss[k]++;
                            if (mErr[k] < ERRMAX_M[k]) mErr[k]++;
                            if (mMiss[k] == LOSS_M[k]) begin
                                mLock[k]  = 1'b0;
                                mPhase[k] = 0;
                                mMiss[k]  = 0;
                                mRun[k]   = 0;
                            end
                        end
                    end else if (mRun[k] > 0 && d == want) begin
                        mRun[k]++;
                        mPhase[k] = (mPhase[k] + 1) % 8;
                        if (mRun[k] == LOCK_M[k]) begin
                            mLock[k] = 1'b1;
                            mMiss[k] = 0;
                        end
                    end else if (d == 4'hA) begin
                        mRun[k]   = 1;
                        mPhase[k] = 1;
                    end else begin
                        mRun[k]   = 0;
                        mPhase[k] = 0;
                    end
                end
                if (clr) mErr[k] = 0;
            end
        end
    endtask

    // Compare every output of both checkers against the model.
    task automatic checkOutput();
        checkValue($sformatf("A.locked@%0d", cyc),      8'(lockedA), 8'(mLock[0]));
        checkValue($sformatf("A.error@%0d", cyc),       8'(errorA),  8'(mErrPulse[0]));
        checkValue($sformatf("A.period_done@%0d", cyc), 8'(pdA),     8'(mPd[0]));
        checkValue($sformatf("A.expected@%0d", cyc),    8'(expA),    8'(SEQ_TB[mPhase[0]]));
        checkValue($sformatf("A.err_count@%0d", cyc),   cntA,        8'(mErr[0]));
        checkValue($sformatf("B.locked@%0d", cyc),      8'(lockedB), 8'(mLock[1]));
        checkValue($sformatf("B.error@%0d", cyc),       8'(errorB),  8'(mErrPulse[1]));
        checkValue($sformatf("B.period_done@%0d", cyc), 8'(pdB),     8'(mPd[1]));
        checkValue($sformatf("B.expected@%0d", cyc),    8'(expB),    8'(SEQ_TB[mPhase[1]]));
        checkValue($sformatf("B.err_count@%0d", cyc),   8'(cntB),    8'(mErr[1]));
    endtask

    // Drive one cycle of inputs, clock it, update the model and check
    // outputs a little after the edge.
    task automatic applyStimulus(input bit v, input logic [3:0] d, input bit clr, input bit rstn);
        valid     = v;
        data      = d;
        clr_count = clr;
        reset_n   = rstn;
        @(posedge clk);
        cyc++;
        modelStep(v, d, clr, rstn);
        #1;
        checkOutput();
    endtask

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        txPhase = 0;
    endtask

    task automatic sendClean(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, SEQ_TB[txPhase], 1'b0, 1'b1);
            txPhase = (txPhase + 1) % 8;
        end
    endtask

    task automatic sendCorrupt(input int n, input bit clr);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, SEQ_TB[txPhase] ^ 4'h8, clr, 1'b1);
            txPhase = (txPhase + 1) % 8;
        end
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        int rate;
        bit rv, rclr, rrst;
        logic [3:0] rd;

        valid     = 1'b0;
        data      = 4'h0;
        clr_count = 1'b0;
        reset_n   = 1'b0;

        // Reset state, then acquisition from a clean start.
        doReset(2);
        checkValue("reset.expected", 8'(expA), 8'h0A);
        sendClean(8);
        checkValue("plan1.locked_after_D", 8'(lockedA), 8'h01);
        sendClean(8);
        checkValue("plan1.period_done", 8'(pdA), 8'h01);

        // Single corrupted F while locked.
        sendClean(4);
        sendCorrupt(1, 1'b0);
        checkValue("plan2.error", 8'(errorA), 8'h01);
        checkValue("plan2.err_count", cntA, 8'h01);
        sendClean(3);

        // Three consecutive corruptions drop lock on the default checker.
        sendClean(2);
        sendCorrupt(3, 1'b0);
        checkValue("plan3.locked_lost", 8'(lockedA), 8'h00);
        checkValue("plan3.err_count", cntA, 8'h04);
        checkValue("plan3.B_still_locked", 8'(lockedB), 8'h01);
        sendClean(3);
        sendClean(8);
        checkValue("plan3.relock", 8'(lockedA), 8'h01);

        // Mid-stream start: hunt until A, then lock after the next D.
        doReset(1);
        txPhase = 3;
        sendClean(12);
        checkValue("plan4.not_yet_locked", 8'(lockedA), 8'h00);
        sendClean(1);
        checkValue("plan4.locked", 8'(lockedA), 8'h01);

        // A stray A during verification restarts alignment.
        doReset(1);
        sendClean(2);
        txPhase = 0;
        sendClean(7);
        checkValue("plan5.not_yet_locked", 8'(lockedA), 8'h00);
        sendClean(1);
        checkValue("plan5.locked", 8'(lockedA), 8'h01);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'h5, 1'b0, 1'b1);
        checkValue("plan5.hold_expected", 8'(expA), 8'h0A);
        sendClean(8);

        // Saturation of the 2-bit counter, clear priority, reset while locked.
        sendCorrupt(5, 1'b0);
        checkValue("plan6.saturated", 8'(cntB), 8'h03);
        checkValue("plan6.B_locked", 8'(lockedB), 8'h01);
        sendCorrupt(1, 1'b1);
        checkValue("plan6.clr_wins", 8'(cntB), 8'h00);
        checkValue("plan6.clr_error_pulse", 8'(errorB), 8'h01);
        doReset(1);
        checkValue("plan6.reset_locked", 8'(lockedB), 8'h00);
        checkValue("plan6.reset_expected", 8'(expB), 8'h0A);

        // Randomized traffic with varying corruption rates, valid gaps,
        // occasional clears, resets and phase slips.
        for (int i = 0; i < 900; i++) begin
            case ((i / 100) % 3)
                0:       rate = 2;
                1:       rate = 15;
                default: rate = 40;
            endcase
            rv   = ($urandom_range(0, 99) < 85);
            rclr = ($urandom_range(0, 49) == 0);
            rrst = ($urandom_range(0, 249) != 0);
            if ($urandom_range(0, 99) < rate) rd = 4'($urandom_range(0, 15));
            else                              rd = SEQ_TB[txPhase];
            applyStimulus(rv, rd, rclr, rrst);
            if (rv) txPhase = (txPhase + 1) % 8;
            if ($urandom_range(0, 199) == 0) txPhase = $urandom_range(0, 7);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/sequence_checker.md
Name: sequence_checker

Overview:
Receive-side counterpart of sequence_generator. It samples the 4-bit stream A,B,E,7,F,2,0,D (repeating) when a valid strobe is high. It acquires alignment, declares lock after a run of correct symbols, counts mismatches while locked, and drops lock after consecutive misses. It sits downstream of sequence_generator (or any link carrying its pattern) as a link-integrity monitor.

Parameters:
LOCK_LEN, 8, number of consecutive correct symbols (starting at A) required to lock; legal range 2..16
LOSS_THRESH, 3, number of consecutive mismatches while locked that forces loss of lock; legal range 1..15
CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  reset, synchronous and active-low
valid  input  1  data qualifier; symbol sampled only when high (driven by generator's enable)
data  input  4  received symbol
clr_count  input  1  synchronous clear of err_count
locked  output  1  high while FSM in LOCKED
error  output  1  one-cycle pulse: a locked-state symbol mismatched
period_done  output  1  one-cycle pulse: locked-state sample of the 8th sequence slot (D position), match or not
expected  output  4  symbol expected at the next valid sample = SEQ[idx]
err_count  output  CNT_W  saturating count of locked-state mismatches

Behaviour:
- Reset (reset_n=0 at rising edge): state=HUNT, idx=0, match_cnt=0, miss_cnt=0; outputs locked=0, error=0, period_done=0, err_count=0, expected=A. Reset mid-operation overrides everything in that cycle.
- valid=0: state, idx and counters hold; error and period_done are 0.
- All outputs are registered. Pulses assert in the cycle after the sampling edge.
- idx: 3-bit pointer into SEQ[0..7]={A,B,E,7,F,2,0,D}; it increments modulo 8 (7 wraps to 0).
- HUNT: on valid with data==A -> VERIFY, idx=1, match_cnt=1. Any other symbol -> stay in HUNT.
- VERIFY, valid, data==SEQ[idx]: idx++, match_cnt++. When the new match_cnt equals LOCK_LEN -> LOCKED, miss_cnt=0.
- VERIFY, valid, mismatch with data==A: restart, VERIFY, idx=1, match_cnt=1.
- VERIFY, valid, mismatch otherwise: -> HUNT, idx=0, match_cnt=0.
- VERIFY mismatches do not touch err_count or error.
- LOCKED, valid: idx always advances (flywheel, no realignment).
  - Match: miss_cnt=0.
  - Mismatch: error=1, err_count+1 saturating at all-ones, miss_cnt++.
  - When the new miss_cnt equals LOSS_THRESH -> HUNT, idx=0, miss_cnt=0, match_cnt=0.
  - period_done=1 when the sampled slot was idx==7.
- clr_count: err_count=0 next cycle. It takes priority over a simultaneous increment.
- locked is low from the cycle after the loss-of-lock edge.

Decomposition:
- Shared package seq_pkg holds:
  - SEQ_LEN=8
  - SEQ symbol constant array {4'hA,4'hB,4'hE,4'h7,4'hF,4'h2,4'h0,4'hD}
  - state enum {HUNT, VERIFY, LOCKED}
- The generator is to be refactored to use the same SEQ constants.
- One natural sub-module: seq_err_counter (saturating counter with clear, width CNT_W).

Test Plan:
1. Reset, valid=1, feed A,B,E,7,F,2,0,D -> locked=1 the cycle after D is sampled; err_count=0. Continue A..D -> period_done pulse after each D.
2. While locked, replace one F with 3 -> single error pulse, err_count=1, locked stays 1. The following 2,0,D produce no error.
3. While locked, corrupt 3 consecutive symbols -> 3 error pulses, err_count+3, locked=0 after the third. A subsequent clean A..D relocks.
4. Start mid-stream 7,F,2,0,D,A,B,E,... -> stays in HUNT until A. locked=1 only after the 8th correct symbol from A; no error pulses during acquisition.
5. VERIFY sequence A,B,A,B,E,7,F,2,0,D -> the second A restarts alignment; lock after that D. valid low for 3 cycles mid-lock with data=5 -> no error, idx holds.
6. CNT_W=2: force 5 locked mismatches with LOSS_THRESH=15 -> err_count saturates at 3. Assert clr_count together with a mismatch -> err_count=0. reset_n=0 while locked -> all outputs at reset values next cycle.
